// File: rtl/dac_ramp_pkg.sv
// rtl/dac_ramp_pkg.sv - shared widths, envelope constants and ramp state encoding
package dac_ramp_pkg;

    localparam int ENV_W = 17;
    localparam int DAC_W = 14;
    localparam logic [ENV_W-1:0] ENV_FULL = 17'd65536;

    typedef enum logic [1:0] {
        RAMP_IDLE = 2'd0,
        RAMP_UP   = 2'd1,
        RAMP_HOLD = 2'd2,
        RAMP_DOWN = 2'd3
    } ramp_state_e;

    // Clamp a 17-bit signed sum into the 16-bit signed range.
    function automatic logic signed [15:0] sat16(input logic signed [16:0] v);
        if (v > 17'sd32767) begin
            return 16'sh7fff;
        end else if (v < -17'sd32768) begin
            return 16'sh8000;
        end else begin
            return v[15:0];
        end
    endfunction

endpackage

// File: rtl/dac_ramp_output_if.sv
// rtl/dac_ramp_output_if.sv - sample input stream and DAC code output stream
// master: drives signal_in/signal_valid, receives dac_out/dac_valid/clip
// slave : the ramp output block
interface dac_ramp_output_if;
    import dac_ramp_pkg::*;

    logic signed [15:0]      signal_in;
    logic                    signal_valid;
    logic signed [DAC_W-1:0] dac_out;
    logic                    dac_valid;
    logic                    clip;

    modport master (output signal_in, signal_valid, input dac_out, dac_valid, clip);
    modport slave  (input signal_in, signal_valid, output dac_out, dac_valid, clip);
endinterface

// File: rtl/dac_ramp_envelope.sv
// rtl/dac_ramp_envelope.sv - ramp envelope FSM (IDLE/UP/HOLD/DOWN)
// in : clk, aresetn, valid (sample strobe), ramp_start, ramp_down_req, ramp_step
// out: env (value used for the current sample), state, done (one-cycle pulse)
module dac_ramp_envelope
    import dac_ramp_pkg::*;
(
    input  logic             clk,
    input  logic             aresetn,
    input  logic             valid,
    input  logic             ramp_start,
    input  logic             ramp_down_req,
    input  logic [15:0]      ramp_step,
    output logic [ENV_W-1:0] env,
    output ramp_state_e      state,
    output logic             done
);

    ramp_state_e      state_q, state_d;
    logic [ENV_W-1:0] env_q, env_d;
    logic             done_q, done_d;
    logic [ENV_W:0]   up_sum;

    always_comb begin
        state_d = state_q;
        env_d   = env_q;
        done_d  = 1'b0;
        up_sum  = {1'b0, env_q} + 18'(ramp_step);

        case (state_q)
            RAMP_IDLE: begin
                env_d = '0;
                if (ramp_start) state_d = RAMP_UP;
            end
            RAMP_UP: begin
                // A down request overrides both a coincident start and the sample update.
                if (ramp_down_req) begin
                    state_d = RAMP_DOWN;
                end else if (valid) begin
                    // A zero step means jump straight to full scale.
                    if (ramp_step == 16'd0 || up_sum >= 18'(ENV_FULL)) begin
                        env_d   = ENV_FULL;
                        state_d = RAMP_HOLD;
                        done_d  = 1'b1;
                    end else begin
                        env_d = up_sum[ENV_W-1:0];
                    end
                end
            end
            RAMP_HOLD: begin
                env_d = ENV_FULL;
                if (ramp_down_req) state_d = RAMP_DOWN;
            end
            RAMP_DOWN: begin
                if (ramp_start) begin
                    state_d = RAMP_UP;
                end else if (valid) begin
                    if (ramp_step == 16'd0 || env_q <= 17'(ramp_step)) begin
                        env_d   = '0;
                        state_d = RAMP_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        env_d = env_q - 17'(ramp_step);
                    end
                end
            end
            default: begin
                state_d = RAMP_IDLE;
                env_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state_q <= RAMP_IDLE;
            env_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            env_q   <= env_d;
            done_q  <= done_d;
        end
    end

    assign env   = env_q;
    assign state = state_q;
    assign done  = done_q;

endmodule

// File: rtl/dac_ramp_output.sv
// rtl/dac_ramp_output.sv - enveloped, offset-corrected, saturating DAC output stage
// clk, aresetn           : clock, synchronous active-low reset
// bus (slave)            : signal_in/signal_valid in, dac_out/dac_valid/clip out
// ramp_start/_down_req   : envelope requests; ramp_step envelope increment
// cal_offset             : signed DC offset added after scaling
// ramp_state/ramp_done   : envelope state and completion pulse
// clip_count             : saturating clip counter, built only with DAC_CLIP_COUNTER_EN
module dac_ramp_output
    import dac_ramp_pkg::*;
(
    input  logic               clk,
    input  logic               aresetn,
    dac_ramp_output_if.slave   bus,
    input  logic               ramp_start,
    input  logic               ramp_down_req,
    input  logic [15:0]        ramp_step,
    input  logic signed [15:0] cal_offset,
    output logic [1:0]         ramp_state,
    output logic               ramp_done,
    output logic [15:0]        clip_count
);

    logic [ENV_W-1:0] env;
    ramp_state_e      env_state;

    dac_ramp_envelope u_env (
        .clk           (clk),
        .aresetn       (aresetn),
        .valid         (bus.signal_valid),
        .ramp_start    (ramp_start),
        .ramp_down_req (ramp_down_req),
        .ramp_step     (ramp_step),
        .env           (env),
        .state         (env_state),
        .done          (ramp_done)
    );

    assign ramp_state = env_state;

    // Stage 1: scale by the pre-update envelope; stage 2: offset + saturate; stage 3: output.
    logic                    s1_valid_q, s1_valid_d;
    logic signed [16:0]      s1_scaled_q, s1_scaled_d;
    logic signed [15:0]      s1_off_q, s1_off_d;
    logic                    s2_valid_q, s2_valid_d;
    logic signed [15:0]      s2_data_q, s2_data_d;
    logic                    s2_clip_q, s2_clip_d;
    logic                    s3_valid_q, s3_valid_d;
    logic signed [DAC_W-1:0] s3_dac_q, s3_dac_d;
    logic                    s3_clip_q, s3_clip_d;

    logic signed [33:0] prod;
    logic signed [16:0] sum;
    logic               unused_bits;

    always_comb begin
        prod = $signed({{18{bus.signal_in[15]}}, bus.signal_in}) * $signed({17'b0, env});

        s1_valid_d  = bus.signal_valid;
        // Slicing [32:16] equals an arithmetic >>> 16 kept to 17 bits.
        s1_scaled_d = prod[32:16];
        s1_off_d    = cal_offset;

        sum        = s1_scaled_q + {s1_off_q[15], s1_off_q};
        s2_valid_d = s1_valid_q;
        s2_data_d  = sat16(sum);
        s2_clip_d  = s1_valid_q && (sum > 17'sd32767 || sum < -17'sd32768);

        s3_valid_d = s2_valid_q;
        s3_dac_d   = s2_data_q[15:2];
        s3_clip_d  = s2_clip_q;
    end

    assign unused_bits = ^{prod[33], prod[15:0], s2_data_q[1:0]};

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            s1_valid_q  <= 1'b0;
            s1_scaled_q <= '0;
            s1_off_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_data_q   <= '0;
            s2_clip_q   <= 1'b0;
            s3_valid_q  <= 1'b0;
            s3_dac_q    <= '0;
            s3_clip_q   <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_scaled_q <= s1_scaled_d;
            s1_off_q    <= s1_off_d;
            s2_valid_q  <= s2_valid_d;
            s2_data_q   <= s2_data_d;
            s2_clip_q   <= s2_clip_d;
            s3_valid_q  <= s3_valid_d;
            s3_dac_q    <= s3_dac_d;
            s3_clip_q   <= s3_clip_d;
        end
    end

    assign bus.dac_out   = s3_dac_q;
    assign bus.dac_valid = s3_valid_q;
    assign bus.clip      = s3_clip_q;

`ifdef DAC_CLIP_COUNTER_EN
    logic [15:0] clip_cnt_q, clip_cnt_d;

    // Counts as the clipped sample is loaded into the output stage.
    always_comb begin
        clip_cnt_d = clip_cnt_q;
        if (s2_valid_q && s2_clip_q && clip_cnt_q != 16'hffff) begin
            clip_cnt_d = clip_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            clip_cnt_q <= '0;
        end else begin
            clip_cnt_q <= clip_cnt_d;
        end
    end

    assign clip_count = clip_cnt_q;
`else
    assign clip_count = '0;
`endif

endmodule
